// File: rtl/mcu_block_fetcher.sv
// Walks the Y-channel capture buffer in 8x8 blocks and streams each block's pixels row-major
// over valid/ready, with block tags carried alongside every pixel through a 2-entry output FIFO.
module mcu_block_fetcher #(
   parameter int IMG_W  = 224,
   parameter int IMG_H  = 224,
   parameter int BLK    = 8,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              all_blocks,
   input  logic [9:0]        blk_idx,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_data,
   output logic              out_first,
   output logic              out_last,
   output logic [9:0]        out_blk_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BX_N = IMG_W / BLK;
   localparam int BY_N = IMG_H / BLK;
   localparam int CW   = $clog2(BLK);
   localparam int BXW  = $clog2(BX_N);
   localparam int BYW  = $clog2(BY_N);

   localparam logic [CW-1:0]     C_MAX  = CW'(BLK - 1);
   localparam logic [BXW-1:0]    BX_MAX = BXW'(BX_N - 1);
   localparam logic [BYW-1:0]    BY_MAX = BYW'(BY_N - 1);
   localparam logic [9:0]        BX_N10 = 10'(BX_N);
   localparam logic [9:0]        N_BLK  = 10'(BX_N * BY_N);
   localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] BROW_A = ADDR_W'(BLK * IMG_W);
   localparam logic [ADDR_W-1:0] BLK_A  = ADDR_W'(BLK);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [CW-1:0]     c_r, r_r;
   logic [BXW-1:0]    bx_r;
   logic [BYW-1:0]    by_r;
   logic              all_r;
   logic              in_flight_r;
   logic              tag_first_r, tag_last_r;
   logic [9:0]        tag_blk_r;
   logic [PIX_W-1:0]  fifo_data_r  [2];
   logic              fifo_first_r [2];
   logic              fifo_last_r  [2];
   logic [9:0]        fifo_blk_r   [2];
   logic              wr_ptr_r, rd_ptr_r;
   logic [1:0]        count_r;
   logic              err_r;

   logic              pop_s, issue_s, last_pix_s, last_read_s;
   logic              bad_start_s, good_start_s, done_s;

   assign pop_s        = (count_r != 2'd0) && out_ready;
   // A slot freed by this cycle's pop counts as credit, which keeps 1 beat/cycle without overrun.
   assign issue_s      = (state_r == S_FETCH) &&
                         (({1'b0, count_r} + {2'b00, in_flight_r}) < (3'd2 + {2'b00, pop_s}));
   assign last_pix_s   = (r_r == C_MAX) && (c_r == C_MAX);
   assign last_read_s  = last_pix_s && (!all_r || ((bx_r == BX_MAX) && (by_r == BY_MAX)));
   assign bad_start_s  = start && !all_blocks && (blk_idx >= N_BLK);
   assign good_start_s = (state_r == S_IDLE) && start && !bad_start_s;

   assign mem_rd_en   = issue_s;
   assign mem_rd_addr = ADDR_W'(by_r) * BROW_A + ADDR_W'(r_r) * ROW_A +
                        ADDR_W'(bx_r) * BLK_A + ADDR_W'(c_r);

   assign out_valid   = (count_r != 2'd0);
   assign out_data    = fifo_data_r[rd_ptr_r];
   assign out_first   = fifo_first_r[rd_ptr_r];
   assign out_last    = fifo_last_r[rd_ptr_r];
   assign out_blk_idx = fifo_blk_r[rd_ptr_r];
   assign busy        = (state_r != S_IDLE);
   assign done        = done_s;
   assign err         = err_r;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and completion pulse
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (good_start_s) begin
               state_s = S_FETCH;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_FETCH: begin
            if (issue_s && last_read_s) begin
               state_s = S_DRAIN;
            end else begin
               state_s = S_FETCH;
            end
         end
         S_DRAIN: begin
            if ((count_r == 2'd0) && !in_flight_r) begin
               state_s = S_IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = S_DRAIN;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Pixel/block walk counters, c fastest then r, bx, by
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_r   <= '0;
         r_r   <= '0;
         bx_r  <= '0;
         by_r  <= '0;
         all_r <= 1'b0;
      end else if (good_start_s) begin
         c_r   <= '0;
         r_r   <= '0;
         all_r <= all_blocks;
         if (all_blocks) begin
            bx_r <= '0;
            by_r <= '0;
         end else begin
            bx_r <= BXW'(blk_idx % BX_N10);
            by_r <= BYW'(blk_idx / BX_N10);
         end
      end else if (issue_s) begin
         if (c_r == C_MAX) begin
            c_r <= '0;
            if (r_r == C_MAX) begin
               r_r <= '0;
               if (bx_r == BX_MAX) begin
                  bx_r <= '0;
                  by_r <= by_r + BYW'(1);
               end else begin
                  bx_r <= bx_r + BXW'(1);
               end
            end else begin
               r_r <= r_r + CW'(1);
            end
         end else begin
            c_r <= c_r + CW'(1);
         end
      end
   end

   // In-flight read flag and the tags that accompany its data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_flight_r <= 1'b0;
         tag_first_r <= 1'b0;
         tag_last_r  <= 1'b0;
         tag_blk_r   <= '0;
      end else begin
         in_flight_r <= issue_s;
         if (issue_s) begin
            tag_first_r <= (r_r == '0) && (c_r == '0);
            tag_last_r  <= last_pix_s;
            tag_blk_r   <= 10'(by_r) * BX_N10 + 10'(bx_r);
         end
      end
   end

   // Output FIFO: pushed by returning read data, popped by the consumer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_r[i]  <= '0;
            fifo_first_r[i] <= 1'b0;
            fifo_last_r[i]  <= 1'b0;
            fifo_blk_r[i]   <= '0;
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (in_flight_r) begin
            fifo_data_r[wr_ptr_r]  <= mem_rd_data;
            fifo_first_r[wr_ptr_r] <= tag_first_r;
            fifo_last_r[wr_ptr_r]  <= tag_last_r;
            fifo_blk_r[wr_ptr_r]   <= tag_blk_r;
            wr_ptr_r               <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_r + {1'b0, in_flight_r} - {1'b0, pop_s};
      end
   end

   // Out-of-range single-block request is flagged one cycle later and dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (state_r == S_IDLE) && bad_start_s;
      end
   end

endmodule

// File: tb/tb_mcu_block_fetcher.sv
// Scoreboard bench for mcu_block_fetcher: expected addresses and beats are queued at request time
// and a negedge monitor pops and compares them as the DUT issues reads and hands out beats.
module tb_mcu_block_fetcher;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        all_blocks;
   logic [9:0]  blk_idx;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr;
   logic [7:0]  mem_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_first;
   logic        out_last;
   logic [9:0]  out_blk_idx;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       l;
      logic [9:0] b;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] addr_q[$];

   int total = 0;
   int bad   = 0;
   int ready_mode = 0;
   int outstanding = 0;
   int accepted = 0;
   int last_cnt = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int cyc = 0;
   int last_beat_cyc = 0;

   mcu_block_fetcher dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .all_blocks  (all_blocks),
      .blk_idx     (blk_idx),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_first   (out_first),
      .out_last    (out_last),
      .out_blk_idx (out_blk_idx),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer model: mem[a] = a[7:0], one cycle read latency
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) mem_rd_data <= 8'd0;
      else if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   task automatic push_block(input int idx);
      int by, bx, a;
      by = idx / 28;
      bx = idx % 28;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            beat_t e;
            a = (by * 8 + r) * 224 + bx * 8 + c;
            addr_q.push_back(a[15:0]);
            e.d = a[7:0];
            e.f = (r == 0) && (c == 0);
            e.l = (r == 7) && (c == 7);
            e.b = idx[9:0];
            exp_q.push_back(e);
         end
      end
   endtask

   // Consumer: out_ready changes just after the rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(7, 0) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: reads, handshakes, hold stability, pulses
   initial begin
      logic        hs;
      logic        hold_prev;
      logic [19:0] held;
      hold_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            outstanding = 0;
            hold_prev = 1'b0;
         end else begin
            hs = out_valid && out_ready;
            if (mem_rd_en) begin
               if (addr_q.size() == 0) fail("addr_extra");
               else chk("rd_addr", {16'd0, mem_rd_addr}, {16'd0, addr_q.pop_front()});
               chk("outstanding_le2", {31'd0, (outstanding + 1 - int'(hs)) <= 2}, 32'd1);
               outstanding++;
            end
            if (hold_prev) begin
               chk("hold_valid", {31'd0, out_valid}, 32'd1);
               chk("hold_beat", {12'd0, out_data, out_first, out_last, out_blk_idx}, {12'd0, held});
            end
            if (hs) begin
               if (exp_q.size() == 0) begin
                  fail("beat_extra");
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                  chk("out_first", {31'd0, out_first}, {31'd0, e.f});
                  chk("out_last", {31'd0, out_last}, {31'd0, e.l});
                  chk("out_blk_idx", {22'd0, out_blk_idx}, {22'd0, e.b});
               end
               outstanding--;
               accepted++;
               if (out_last) begin
                  last_cnt++;
                  last_beat_cyc = cyc;
               end
            end
            hold_prev = out_valid && !out_ready;
            held = {out_data, out_first, out_last, out_blk_idx};
            if (done) done_cnt++;
            if (err) err_cnt++;
         end
      end
   end

   task automatic do_start(input logic all, input int idx, input logic ok);
      @(posedge clk);
      #1;
      start = 1'b1;
      all_blocks = all;
      blk_idx = idx[9:0];
      @(negedge clk);
      chk("busy_at_start", {31'd0, busy}, 32'd0);
      chk("rd_en_at_start", {31'd0, mem_rd_en}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", {31'd0, busy}, {31'd0, ok});
      chk("first_rd_en", {31'd0, mem_rd_en}, {31'd0, ok});
      chk("err_after_start", {31'd0, err}, {31'd0, !ok});
   endtask

   task automatic wait_done(input int budget);
      logic got;
      got = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         fail("done_timeout");
      end else begin
         chk("done_after_last_beat", cyc - last_beat_cyc, 32'd1);
         chk("busy_with_done", {31'd0, busy}, 32'd1);
      end
      chk("exp_q_drained", exp_q.size(), 32'd0);
      chk("addr_q_drained", addr_q.size(), 32'd0);
   endtask

   initial begin
      int a0, l0, d0, e0;
      reset_n = 1'b0;
      start = 1'b0;
      all_blocks = 1'b0;
      blk_idx = 10'd0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("rst_done_err", {30'd0, done, err}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Block 0, latency and full throughput
      a0 = accepted;
      l0 = last_cnt;
      push_block(0);
      do_start(1'b0, 0, 1'b1);
      @(negedge clk);
      chk("valid_T2", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("valid_T3", {31'd0, out_valid}, 32'd1);
      wait_done(200);
      chk("blk0_beats", accepted - a0, 32'd64);
      chk("blk0_lasts", last_cnt - l0, 32'd1);

      // Last block of the frame
      push_block(783);
      do_start(1'b0, 783, 1'b1);
      wait_done(200);

      // Consumer stall of 20 cycles mid-block
      push_block(100);
      do_start(1'b0, 100, 1'b1);
      repeat (25) @(negedge clk);
      ready_mode = 2;
      repeat (20) @(negedge clk);
      ready_mode = 0;
      wait_done(300);

      // Out-of-range single block request
      e0 = err_cnt;
      do_start(1'b0, 784, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bad_busy", {31'd0, busy}, 32'd0);
         chk("bad_rd_en", {31'd0, mem_rd_en}, 32'd0);
      end
      chk("bad_err_pulses", err_cnt - e0, 32'd1);

      // Whole frame under random backpressure
      a0 = accepted;
      l0 = last_cnt;
      for (int b = 0; b < 784; b++) push_block(b);
      ready_mode = 1;
      do_start(1'b1, 0, 1'b1);
      wait_done(80000);
      ready_mode = 0;
      chk("frame_beats", accepted - a0, 32'd50176);
      chk("frame_lasts", last_cnt - l0, 32'd784);

      // Reset mid-frame, then restart at block 5
      for (int b = 0; b < 784; b++) push_block(b);
      do_start(1'b1, 0, 1'b1);
      repeat (200) @(negedge clk);
      d0 = done_cnt;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      exp_q.delete();
      addr_q.delete();
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_beat", {12'd0, out_data, out_first, out_last, out_blk_idx}, 32'd0);
      chk("mid_rst_addr", {16'd0, mem_rd_addr}, 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("no_done_on_abort", done_cnt - d0, 32'd0);
      push_block(5);
      do_start(1'b0, 5, 1'b1);
      wait_done(200);

      chk("total_done_pulses", done_cnt, 32'd5);
      chk("total_err_pulses", err_cnt, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
